// File: rtl/tm1638_key_reader.sv
// TM1638 key-scan reader: sends the read command over STB/CLK/DIO, turns DIO
// around and shifts in the 32-bit key matrix, presenting raw keys and 8 buttons.
module tm1638_key_reader #(
  parameter int          HALF_PERIOD = 25,
  parameter int          WAIT_HALVES = 4,
  parameter logic [7:0]  CMD_READ    = 8'h42
) (
  input  logic        clki,
  input  logic        rstn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] keys,
  output logic [7:0]  buttons,
  output logic        tm_stb,
  output logic        tm_clk,
  output logic        tm_dio_out,
  output logic        tm_dio_oe,
  input  logic        tm_dio_in
);

  localparam int              CNT_W     = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);
  localparam logic [6:0]      WAIT_LAST = 7'(WAIT_HALVES - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_STB_SETUP = 3'd1,
    ST_CMD       = 3'd2,
    ST_WAIT      = 3'd3,
    ST_READ      = 3'd4,
    ST_STB_END   = 3'd5
  } state_t;

  // Buttons sit at bits 0 and 4 of each scan byte.
  function automatic logic [7:0] decode_buttons(input logic [31:0] scan);
    logic [7:0] b;
    for (int k = 0; k < 4; k++) begin
      b[k]     = scan[8*k];
      b[k + 4] = scan[8*k + 4];
    end
    return b;
  endfunction

  state_t            state_r, state_s;
  logic [6:0]        half_r, half_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              tick_s;
  logic              sample_s, finish_s;
  logic              dio_meta_r, dio_sync_r;
  logic [31:0]       shift_r;
  logic              stb_s, clk_s, dio_out_s, oe_s, busy_s;

  assign tick_s = (cnt_r == CNT_LAST);

  // Next-state and half-period index sequencing.
  always_comb begin
    state_s  = state_r;
    half_s   = half_r;
    sample_s = 1'b0;
    finish_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        half_s = 7'd0;
        if (start) begin
          state_s = ST_STB_SETUP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_STB_SETUP: begin
        if (tick_s) begin
          state_s = ST_CMD;
          half_s  = 7'd0;
        end else begin
          state_s = ST_STB_SETUP;
        end
      end
      ST_CMD: begin
        if (tick_s && half_r == 7'd15) begin
          state_s = ST_WAIT;
          half_s  = 7'd0;
        end else if (tick_s) begin
          half_s = half_r + 7'd1;
        end else begin
          half_s = half_r;
        end
      end
      ST_WAIT: begin
        if (tick_s && half_r == WAIT_LAST) begin
          state_s = ST_READ;
          half_s  = 7'd0;
        end else if (tick_s) begin
          half_s = half_r + 7'd1;
        end else begin
          half_s = half_r;
        end
      end
      ST_READ: begin
        // Odd halves are high; their closing tick is the sample point.
        sample_s = tick_s & half_r[0];
        if (tick_s && half_r == 7'd63) begin
          state_s = ST_STB_END;
          half_s  = 7'd0;
        end else if (tick_s) begin
          half_s = half_r + 7'd1;
        end else begin
          half_s = half_r;
        end
      end
      ST_STB_END: begin
        if (tick_s) begin
          state_s  = ST_IDLE;
          half_s   = 7'd0;
          finish_s = 1'b1;
        end else begin
          state_s = ST_STB_END;
        end
      end
      default: begin
        state_s = ST_IDLE;
        half_s  = 7'd0;
      end
    endcase
  end

  // Bus levels derived from the upcoming state so the pins come straight off flops.
  always_comb begin
    stb_s     = 1'b1;
    clk_s     = 1'b1;
    dio_out_s = 1'b1;
    oe_s      = 1'b0;
    busy_s    = (state_s != ST_IDLE);
    case (state_s)
      ST_IDLE: begin
        stb_s = 1'b1;
      end
      ST_STB_SETUP: begin
        stb_s = 1'b0;
        oe_s  = 1'b1;
      end
      ST_CMD: begin
        stb_s     = 1'b0;
        oe_s      = 1'b1;
        clk_s     = half_s[0];
        dio_out_s = CMD_READ[half_s[3:1]];
      end
      ST_WAIT: begin
        stb_s = 1'b0;
      end
      ST_READ: begin
        stb_s = 1'b0;
        clk_s = half_s[0];
      end
      ST_STB_END: begin
        stb_s = 1'b0;
      end
      default: begin
        stb_s = 1'b1;
      end
    endcase
  end

  // State and half index registers.
  always_ff @(posedge clki or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
      half_r  <= 7'd0;
    end else begin
      state_r <= state_s;
      half_r  <= half_s;
    end
  end

  // Half-period timebase, held at zero while idle.
  always_ff @(posedge clki or negedge rstn) begin
    if (!rstn) begin
      cnt_r <= '0;
    end else if (state_r == ST_IDLE || tick_s) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Two-flop synchronizer for the DIO pad and the LSB-first capture shifter.
  always_ff @(posedge clki or negedge rstn) begin
    if (!rstn) begin
      dio_meta_r <= 1'b1;
      dio_sync_r <= 1'b1;
      shift_r    <= 32'd0;
    end else begin
      dio_meta_r <= tm_dio_in;
      dio_sync_r <= dio_meta_r;
      if (sample_s) begin
        shift_r <= {dio_sync_r, shift_r[31:1]};
      end else begin
        shift_r <= shift_r;
      end
    end
  end

  // Registered outputs; results publish only with done.
  always_ff @(posedge clki or negedge rstn) begin
    if (!rstn) begin
      tm_stb     <= 1'b1;
      tm_clk     <= 1'b1;
      tm_dio_out <= 1'b1;
      tm_dio_oe  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      keys       <= 32'd0;
      buttons    <= 8'd0;
    end else begin
      tm_stb     <= stb_s;
      tm_clk     <= clk_s;
      tm_dio_out <= dio_out_s;
      tm_dio_oe  <= oe_s;
      busy       <= busy_s;
      done       <= finish_s;
      if (finish_s) begin
        keys    <= shift_r;
        buttons <= decode_buttons(shift_r);
      end else begin
        keys    <= keys;
        buttons <= buttons;
      end
    end
  end

endmodule

// File: tb/tb_tm1638_key_reader.sv
// Directed bench for tm1638_key_reader: default-timing instance plus a
// HALF_PERIOD=2 instance, each served by a behavioural TM1638 key model.
module tb_tm1638_key_reader;

  logic        clki = 1'b0;
  logic        rstn = 1'b1;
  logic        start = 1'b0, start2 = 1'b0;
  logic        busy, done, busy2, done2;
  logic [31:0] keys, keys2;
  logic [7:0]  buttons, buttons2;
  logic        tm_stb, tm_clk, tm_dio_out, tm_dio_oe, tm_dio_in;
  logic        tm_stb2, tm_clk2, tm_dio_out2, tm_dio_oe2, tm_dio_in2;

  int n_checks = 0;
  int n_fail   = 0;

  tm1638_key_reader dut (
    .clki(clki), .rstn(rstn), .start(start), .busy(busy), .done(done),
    .keys(keys), .buttons(buttons), .tm_stb(tm_stb), .tm_clk(tm_clk),
    .tm_dio_out(tm_dio_out), .tm_dio_oe(tm_dio_oe), .tm_dio_in(tm_dio_in)
  );

  tm1638_key_reader #(.HALF_PERIOD(2), .WAIT_HALVES(4)) dut2 (
    .clki(clki), .rstn(rstn), .start(start2), .busy(busy2), .done(done2),
    .keys(keys2), .buttons(buttons2), .tm_stb(tm_stb2), .tm_clk(tm_clk2),
    .tm_dio_out(tm_dio_out2), .tm_dio_oe(tm_dio_oe2), .tm_dio_in(tm_dio_in2)
  );

  always #5 clki = ~clki;

  int cyc = 0;
  always @(posedge clki) cyc <= cyc + 1;

  // Key models: drive the next scan bit after each falling CLK while DIO is released.
  logic [31:0] key_data  = 32'h1100_1001;
  logic [31:0] key_data2 = 32'h1100_1001;
  int kidx = 0, kidx2 = 0;
  always @(negedge tm_clk or posedge tm_stb) begin
    if (tm_stb) begin kidx = 0; tm_dio_in = 1'b1; end
    else if (!tm_dio_oe && kidx < 32) begin tm_dio_in = key_data[kidx]; kidx++; end
  end
  always @(negedge tm_clk2 or posedge tm_stb2) begin
    if (tm_stb2) begin kidx2 = 0; tm_dio_in2 = 1'b1; end
    else if (!tm_dio_oe2 && kidx2 < 32) begin tm_dio_in2 = key_data2[kidx2]; kidx2++; end
  end

  // Command capture on CLK rising edges while the master drives DIO.
  int         cmd_rises = 0;
  logic [7:0] cmd_sr = 8'd0;
  always @(posedge tm_clk) begin
    if (tm_dio_oe === 1'b1) begin
      cmd_rises++;
      cmd_sr = {tm_dio_out, cmd_sr[7:1]};
    end
  end

  // Latency and tm_clk level-length monitors.
  logic busy_q = 1'b0, busy2_q = 1'b0, clk2_q = 1'b1;
  int rise_cyc = 0, rise2_cyc = 0, done_cnt = 0, done2_cnt = 0, last_lat = 0, last_lat2 = 0;
  int run2 = 0, falls2 = 0, viol2 = 0;
  bit run_ok2 = 1'b0;
  always @(negedge clki) begin
    if (busy && !busy_q) rise_cyc = cyc;
    if (done) begin done_cnt++; last_lat = cyc - rise_cyc; end
    busy_q = busy;
    if (busy2 && !busy2_q) rise2_cyc = cyc;
    if (done2) begin done2_cnt++; last_lat2 = cyc - rise2_cyc; end
    busy2_q = busy2;
    if (busy2 && tm_clk2 !== clk2_q) begin
      if (run_ok2) begin
        if (clk2_q == 1'b0) begin
          if (run2 != 2) viol2++;
        end else begin
          if (run2 != 2 && run2 != 10) viol2++;
        end
      end
      if (tm_clk2 == 1'b0) falls2++;
      run_ok2 = 1'b1;
      run2 = 1;
    end else if (busy2) begin
      run2++;
    end else begin
      run_ok2 = 1'b0;
      run2 = 0;
    end
    clk2_q = tm_clk2;
  end

  task automatic step();
    @(negedge clki);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, input string name, output bit ok);
    int base;
    base = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      step();
      if (done_cnt != base) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL %s: no done within %0d cycles", name, max); end
  endtask

  task automatic test_reset();
    int bad;
    #2 rstn = 1'b0;
    #1;
    n_checks++; if (tm_stb !== 1'b1)     begin n_fail++; $display("FAIL rst_stb: got %b exp 1", tm_stb); end
    n_checks++; if (tm_clk !== 1'b1)     begin n_fail++; $display("FAIL rst_clk: got %b exp 1", tm_clk); end
    n_checks++; if (tm_dio_out !== 1'b1) begin n_fail++; $display("FAIL rst_dio_out: got %b exp 1", tm_dio_out); end
    n_checks++; if (tm_dio_oe !== 1'b0)  begin n_fail++; $display("FAIL rst_oe: got %b exp 0", tm_dio_oe); end
    n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL rst_busy: got %b exp 0", busy); end
    n_checks++; if (done !== 1'b0)       begin n_fail++; $display("FAIL rst_done: got %b exp 0", done); end
    n_checks++; if (keys !== 32'd0)      begin n_fail++; $display("FAIL rst_keys: got %h exp 0", keys); end
    n_checks++; if (buttons !== 8'd0)    begin n_fail++; $display("FAIL rst_buttons: got %h exp 0", buttons); end
    repeat (3) step();
    rstn = 1'b1;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (tm_stb !== 1'b1 || tm_clk !== 1'b1 || tm_dio_oe !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL idle_bus: %0d bad cycles exp 0", bad); end
  endtask

  task automatic test_cmd_and_read();
    int base_rises;
    bit ok;
    base_rises = cmd_rises;
    key_data = 32'h1100_1001;
    pulse_start();
    wait_done(2400, "scan1_done", ok);
    n_checks++; if (cmd_rises - base_rises != 8) begin n_fail++; $display("FAIL cmd_edges: got %0d exp 8", cmd_rises - base_rises); end
    n_checks++; if (cmd_sr !== 8'h42) begin n_fail++; $display("FAIL cmd_byte: got %h exp 42", cmd_sr); end
    n_checks++; if (last_lat != 2150) begin n_fail++; $display("FAIL scan1_latency: got %0d exp 2150", last_lat); end
    n_checks++; if (keys !== 32'h1100_1001) begin n_fail++; $display("FAIL scan1_keys: got %h exp 11001001", keys); end
    n_checks++; if (buttons !== 8'hA9) begin n_fail++; $display("FAIL scan1_buttons: got %h exp a9", buttons); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL scan1_busy_at_done: got %b exp 0", busy); end
    step();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_width: got %b exp 0", done); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    key_data = 32'h8421_F00F;
    start = 1'b1;
    repeat (50) step();
    n_checks++; if (keys !== 32'h1100_1001) begin n_fail++; $display("FAIL keys_hold: got %h exp 11001001", keys); end
    for (int s = 0; s < 3; s++) begin
      wait_done(2400, "b2b_done", ok);
      n_checks++; if (last_lat != 2150) begin n_fail++; $display("FAIL b2b_latency%0d: got %0d exp 2150", s, last_lat); end
    end
    start = 1'b0;
    n_checks++; if (keys !== 32'h8421_F00F) begin n_fail++; $display("FAIL b2b_keys: got %h exp 8421f00f", keys); end
    n_checks++; if (buttons !== 8'h25) begin n_fail++; $display("FAIL b2b_buttons: got %h exp 25", buttons); end
    repeat (10) step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_stop: got busy %b exp 0", busy); end
  endtask

  task automatic test_reset_mid_read();
    int base_done;
    bit ok;
    key_data = 32'h1100_1001;
    base_done = done_cnt;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (kidx >= 11) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL reach_bit10: got kidx %0d exp 11", kidx); end
    #2 rstn = 1'b0;
    #1;
    n_checks++; if (tm_stb !== 1'b1)     begin n_fail++; $display("FAIL abort_stb: got %b exp 1", tm_stb); end
    n_checks++; if (tm_clk !== 1'b1)     begin n_fail++; $display("FAIL abort_clk: got %b exp 1", tm_clk); end
    n_checks++; if (tm_dio_oe !== 1'b0)  begin n_fail++; $display("FAIL abort_oe: got %b exp 0", tm_dio_oe); end
    n_checks++; if (tm_dio_out !== 1'b1) begin n_fail++; $display("FAIL abort_dio_out: got %b exp 1", tm_dio_out); end
    n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL abort_busy: got %b exp 0", busy); end
    n_checks++; if (keys !== 32'd0)      begin n_fail++; $display("FAIL abort_keys: got %h exp 0", keys); end
    n_checks++; if (buttons !== 8'd0)    begin n_fail++; $display("FAIL abort_buttons: got %h exp 0", buttons); end
    repeat (5) step();
    rstn = 1'b1;
    repeat (2200) step();
    n_checks++; if (done_cnt != base_done) begin n_fail++; $display("FAIL abort_no_done: got %0d dones exp 0", done_cnt - base_done); end
    n_checks++; if (keys !== 32'd0) begin n_fail++; $display("FAIL abort_keys_hold: got %h exp 0", keys); end
    pulse_start();
    wait_done(2400, "after_abort_done", ok);
    n_checks++; if (last_lat != 2150) begin n_fail++; $display("FAIL after_abort_latency: got %0d exp 2150", last_lat); end
    n_checks++; if (keys !== 32'h1100_1001) begin n_fail++; $display("FAIL after_abort_keys: got %h exp 11001001", keys); end
  endtask

  task automatic test_half_period_2();
    int base_done2, base_falls, base_viol;
    bit ok;
    base_done2 = done2_cnt;
    base_falls = falls2;
    base_viol  = viol2;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (done2_cnt != base_done2) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL hp2_done: no done within 400 cycles"); end
    n_checks++; if (last_lat2 != 172) begin n_fail++; $display("FAIL hp2_latency: got %0d exp 172", last_lat2); end
    n_checks++; if (falls2 - base_falls != 40) begin n_fail++; $display("FAIL hp2_clk_falls: got %0d exp 40", falls2 - base_falls); end
    n_checks++; if (viol2 != base_viol) begin n_fail++; $display("FAIL hp2_level_len: got %0d bad levels exp 0", viol2 - base_viol); end
    n_checks++; if (keys2 !== 32'h1100_1001) begin n_fail++; $display("FAIL hp2_keys: got %h exp 11001001", keys2); end
    n_checks++; if (buttons2 !== 8'hA9) begin n_fail++; $display("FAIL hp2_buttons: got %h exp a9", buttons2); end
  endtask

  initial begin
    test_reset();
    test_cmd_and_read();
    test_back_to_back();
    test_reset_mid_read();
    test_half_period_2();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
